rr_arbiter_8x3: RTL and testbench

RR_ARBITER_8X3 -- requirements
Module: rr_arbiter_8x3

---
 rtl/rr_arbiter_8x3.sv | 140 ++++++++++++++
 tb/tb_rr_arbiter_8x3.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8x3.sv
// rr_arbiter_8x3: eight-way round-robin arbiter with a registered one-hot grant.
// A grant is held while its requester keeps asking, up to HOLD_MAX cycles.
// Every release advances the priority pointer past the released requester,
// and one idle cycle always separates two grants.
module rr_arbiter_8x3 #(
    parameter int unsigned HOLD_MAX = 16  // legal range 1..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Hold-counter value at which a still-requesting owner is released.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_id_q, gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;

    logic [7:0] req_rot;    // requests rotated so bit 0 is the priority head
    logic [2:0] win_off;    // offset of the winner from the pointer
    logic       win_found;
    logic [2:0] win_idx;    // absolute index of the winner
    logic       owner_req;  // current owner still requesting
    logic       release_now;

    // Rotate the request vector so that requester ptr_q lands on bit 0.
    always_comb begin
        // NOTE: every variable written in an always_comb gets a default first,
        // otherwise a path that skips the assignment infers a latch.
        req_rot = '0;
        for (int k = 0; k < 8; k++) begin
            req_rot[k] = req[3'(ptr_q + 3'(k))];
        end
    end

    // Find the lowest set bit of the rotated vector (nearest to the pointer).
    always_comb begin
        win_off   = '0;
        win_found = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_off   = 3'(k);
                win_found = 1'b1;
            end
        end
    end

    // Undo the rotation; the 3-bit add wraps modulo 8 on its own.
    assign win_idx     = ptr_q + win_off;
    assign owner_req   = req[gnt_id_q];
    assign release_now = !owner_req || (hold_cnt_q == HOLD_LAST);

    // Next-state and next-output logic for the IDLE/GRANT machine.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (en && win_found) begin
                    state_d     = ST_GRANT;
                    gnt_d       = 8'h01 << win_idx;
                    gnt_id_d    = win_idx;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end else begin
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                end
            end

            ST_GRANT: begin
                // en and the non-owner request bits are deliberately ignored
                // here; only the owner's request and the hold limit matter.
                if (release_now) begin
                    state_d     = ST_IDLE;
                    ptr_d       = gnt_id_q + 3'd1;
                    hold_cnt_d  = '0;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                end else begin
                    hold_cnt_d  = hold_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                hold_cnt_d  = '0;
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // State, pointer, hold counter and registered outputs; reset is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop, independent of order.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter_8x3.sv
// tb_rr_arbiter_8x3: scoreboard bench for the round-robin arbiter.
// Two instances share stimulus: one with HOLD_MAX=4 (timeout scenarios) and
// one with HOLD_MAX=1 (single-cycle grants). A behavioural model predicts the
// outputs after each edge; a monitor pops and compares after every edge.
module tb_rr_arbiter_8x3;

    localparam int HOLD_A = 4;
    localparam int HOLD_B = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req;

    logic [7:0] gnt_a, gnt_b;
    logic [2:0] gnt_id_a, gnt_id_b;
    logic       gnt_valid_a, gnt_valid_b;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       valid;
    } out_t;

    typedef struct packed {
        out_t a;
        out_t b;
    } exp_t;

    exp_t sb_q[$];

    int checks   = 0;
    int failures = 0;

    // Behavioural model state, one entry per instance.
    int m_busy[2];
    int m_owner[2];
    int m_ptr[2];
    int m_held[2];  // cycles the current owner has held its grant so far
    int m_hold[2] = '{HOLD_A, HOLD_B};

    always #5 clk = ~clk;

    rr_arbiter_8x3 #(.HOLD_MAX(HOLD_A)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt_a),
        .gnt_id    (gnt_id_a),
        .gnt_valid (gnt_valid_a)
    );

    rr_arbiter_8x3 #(.HOLD_MAX(HOLD_B)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt_b),
        .gnt_id    (gnt_id_b),
        .gnt_valid (gnt_valid_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i]  = 0;
            m_owner[i] = 0;
            m_ptr[i]   = 0;
            m_held[i]  = 0;
        end
    endfunction

    // One clock edge of the arbiter rules, given the inputs sampled at it.
    function automatic void model_step(input logic [7:0] r, input logic e);
        for (int i = 0; i < 2; i++) begin
            if (m_busy[i] != 0) begin
                if (r[m_owner[i]] == 1'b0 || m_held[i] == m_hold[i]) begin
                    m_busy[i] = 0;
                    m_ptr[i]  = (m_owner[i] + 1) % 8;
                end else begin
                    m_held[i] = m_held[i] + 1;
                end
            end else if (e && r != 8'h00) begin
                int found;
                found = 0;
                for (int k = 0; k < 8; k++) begin
                    int idx;
                    idx = (m_ptr[i] + k) % 8;
                    if (found == 0 && r[idx]) begin
                        found      = 1;
                        m_busy[i]  = 1;
                        m_owner[i] = idx;
                        m_held[i]  = 1;
                    end
                end
            end
        end
    endfunction

    function automatic out_t model_out(input int i);
        out_t o;
        o.valid = (m_busy[i] != 0);
        o.gnt   = (m_busy[i] != 0) ? 8'(1 << m_owner[i]) : 8'h00;
        o.id    = (m_busy[i] != 0) ? 3'(m_owner[i]) : 3'd0;
        return o;
    endfunction

    function automatic void push_exp();
        exp_t x;
        x.a = model_out(0);
        x.b = model_out(1);
        sb_q.push_back(x);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt_a"},   32'(gnt_a),       32'h0);
        check({tag, "_id_a"},    32'(gnt_id_a),    32'h0);
        check({tag, "_valid_a"}, 32'(gnt_valid_a), 32'h0);
        check({tag, "_gnt_b"},   32'(gnt_b),       32'h0);
        check({tag, "_id_b"},    32'(gnt_id_b),    32'h0);
        check({tag, "_valid_b"}, 32'(gnt_valid_b), 32'h0);
    endtask

    // Drive one cycle of inputs at the falling edge, optionally preceded by an
    // asynchronous reset pulse that must clear the outputs before the next edge.
    task automatic drive(input logic [7:0] r, input logic e, input bit pulse);
        @(negedge clk);
        if (pulse) begin
            #1 rst_n = 1'b0;
            #1 check_all_zero("async_rst");
            #1 rst_n = 1'b1;
            model_reset();
        end
        req = r;
        en  = e;
        model_step(r, e);
        push_exp();
    endtask

    // Monitor: after every rising edge, compare outputs with the oldest prediction.
    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                check("gnt_a",       32'(gnt_a),       32'(x.a.gnt));
                check("gnt_id_a",    32'(gnt_id_a),    32'(x.a.id));
                check("gnt_valid_a", 32'(gnt_valid_a), 32'(x.a.valid));
                check("gnt_b",       32'(gnt_b),       32'(x.b.gnt));
                check("gnt_id_b",    32'(gnt_id_b),    32'(x.b.id));
                check("gnt_valid_b", 32'(gnt_valid_b), 32'(x.b.valid));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin : stimulus
        logic [7:0] r;
        logic       e;
        bit         p;

        rst_n = 1'b0;
        req   = 8'h00;
        en    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");

        // Release reset at a falling edge; the next rising edge sees idle inputs.
        @(negedge clk);
        rst_n = 1'b1;
        model_step(8'h00, 1'b0);
        push_exp();

        // Single requester, then pointer left at 4 shown by req=0x11 picking 4.
        drive(8'h08, 1'b1, 1'b0);
        drive(8'h00, 1'b1, 1'b0);
        drive(8'h00, 1'b1, 1'b0);
        drive(8'h11, 1'b1, 1'b0);
        drive(8'h11, 1'b1, 1'b0);
        drive(8'h00, 1'b1, 1'b0);
        drive(8'h00, 1'b1, 1'b0);

        // Fairness: all request, each owner drops after two granted cycles.
        drive(8'hFF, 1'b1, 1'b1);
        for (int n = 0; n < 30; n++) begin
            r = 8'hFF;
            if (m_busy[0] != 0 && m_held[0] == 2) r[m_owner[0]] = 1'b0;
            drive(r, 1'b1, 1'b0);
        end

        // Timeout: two persistent requesters alternate every HOLD_MAX cycles.
        drive(8'h21, 1'b1, 1'b1);
        for (int n = 0; n < 20; n++) drive(8'h21, 1'b1, 1'b0);

        // Pointer wrap: after releasing 7, requester 0 beats 7.
        drive(8'h80, 1'b1, 1'b1);
        drive(8'h80, 1'b1, 1'b0);
        drive(8'h00, 1'b1, 1'b0);
        drive(8'h00, 1'b1, 1'b0);
        drive(8'h81, 1'b1, 1'b0);
        drive(8'h81, 1'b1, 1'b0);
        drive(8'h00, 1'b1, 1'b0);
        drive(8'h00, 1'b1, 1'b0);

        // Enable gating: no grant while en=0; held grant survives en dropping.
        drive(8'h10, 1'b0, 1'b1);
        for (int n = 0; n < 3; n++) drive(8'h10, 1'b0, 1'b0);
        drive(8'h10, 1'b1, 1'b0);
        drive(8'h10, 1'b0, 1'b0);
        drive(8'h10, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0);

        // Async reset mid-grant of requester 2, then search restarts at 0.
        drive(8'h04, 1'b1, 1'b1);
        drive(8'h04, 1'b1, 1'b0);
        drive(8'h06, 1'b1, 1'b1);
        drive(8'h06, 1'b1, 1'b0);
        drive(8'h00, 1'b1, 1'b0);
        drive(8'h00, 1'b1, 1'b0);

        // Random traffic: sticky, sometimes sparse requests, mostly enabled,
        // with occasional asynchronous reset pulses.
        r = 8'h00;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(1, 0) == 0) begin
                r = 8'($urandom);
                if ($urandom_range(1, 0) == 0) r = r & 8'($urandom);
            end
            e = ($urandom_range(3, 0) != 0);
            p = ($urandom_range(63, 0) == 0);
            drive(r, e, p);
        end

        drive(8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
